// File: rtl/gc_joybus_rx.sv
// Joybus bit/frame decoder: classifies bit cells by low time and strobes completed frames.
// Define GC_JOYBUS_RX_BYTE_STROBE_EN to add byte_data/byte_valid per committed data byte.
module gc_joybus_rx #(
   parameter int unsigned CNT_W       = 9,
   parameter int unsigned THRESH      = 100,
   parameter int unsigned LOW_MAX     = 400,
   parameter int unsigned IDLE_CYCLES = 250
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        line,
   input  logic        rx_en,
   output logic        busy,
   output logic        frame_valid,
   output logic [63:0] frame_data,
   output logic [6:0]  frame_len,
   output logic        frame_err
`ifdef GC_JOYBUS_RX_BYTE_STROBE_EN
   ,
   output logic [7:0]  byte_data,
   output logic        byte_valid
`endif
);

   typedef enum logic [1:0] {StArm, StIdle, StLow, StHigh} state_e;

   localparam logic [CNT_W-1:0] ThreshCnt = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] LowMaxCnt = CNT_W'(LOW_MAX);
   localparam logic [CNT_W-1:0] IdleCnt   = CNT_W'(IDLE_CYCLES);
   localparam logic [6:0]       MaxLen    = 7'd64;

   state_e           state_q, state_d;
   logic             line_q;
   logic             fall, rise;
   logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d, lo_cnt_inc;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, hi_cnt_inc;
   logic [63:0]      shreg_q, shreg_d;
   logic [6:0]       len_q, len_d;
   logic             ovf_q, ovf_d;
   logic             pend_vld_q, pend_vld_d;
   logic             pend_bit_q, pend_bit_d;
   logic             fvalid_q, fvalid_d;
   logic [63:0]      fdata_q, fdata_d;
   logic [6:0]       flen_q, flen_d;
   logic             ferr_q, ferr_d;

   assign fall = line_q & ~line;
   assign rise = ~line_q & line;

   assign lo_cnt_inc = (lo_cnt_q == '1) ? lo_cnt_q : lo_cnt_q + CNT_W'(1);
   assign hi_cnt_inc = (hi_cnt_q == '1) ? hi_cnt_q : hi_cnt_q + CNT_W'(1);

   assign busy        = (state_q == StLow) || (state_q == StHigh);
   assign frame_valid = fvalid_q;
   assign frame_data  = fdata_q;
   assign frame_len   = flen_q;
   assign frame_err   = ferr_q;

   always_comb begin
      state_d    = state_q;
      lo_cnt_d   = lo_cnt_q;
      hi_cnt_d   = hi_cnt_q;
      shreg_d    = shreg_q;
      len_d      = len_q;
      ovf_d      = ovf_q;
      pend_vld_d = pend_vld_q;
      pend_bit_d = pend_bit_q;
      fvalid_d   = 1'b0;
      fdata_d    = fdata_q;
      flen_d     = flen_q;
      ferr_d     = ferr_q;

      if (!rx_en) begin
         state_d    = StArm;
         lo_cnt_d   = '0;
         hi_cnt_d   = '0;
         shreg_d    = '0;
         len_d      = '0;
         ovf_d      = 1'b0;
         pend_vld_d = 1'b0;
         pend_bit_d = 1'b0;
      end else begin
         unique case (state_q)
            // Arm only after a long continuous high so we never join mid-frame.
            StArm: begin
               if (line) begin
                  hi_cnt_d = hi_cnt_inc;
                  if (hi_cnt_inc >= IdleCnt) begin
                     state_d  = StIdle;
                     hi_cnt_d = '0;
                  end
               end else begin
                  hi_cnt_d = '0;
               end
            end
            StIdle: begin
               if (fall) begin
                  state_d    = StLow;
                  lo_cnt_d   = CNT_W'(1);
                  shreg_d    = '0;
                  len_d      = '0;
                  ovf_d      = 1'b0;
                  pend_vld_d = 1'b0;
                  pend_bit_d = 1'b0;
               end
            end
            StLow: begin
               if (rise) begin
                  state_d  = StHigh;
                  hi_cnt_d = CNT_W'(1);
                  lo_cnt_d = '0;
                  // Bits are committed one cell late so the final (stop) bit never lands.
                  if (pend_vld_q) begin
                     if (len_q == MaxLen) begin
                        ovf_d = 1'b1;
                     end else begin
                        shreg_d = {shreg_q[62:0], pend_bit_q};
                        len_d   = len_q + 7'd1;
                     end
                  end
                  pend_vld_d = 1'b1;
                  pend_bit_d = (lo_cnt_q < ThreshCnt);
               end else if (!line) begin
                  lo_cnt_d = lo_cnt_inc;
                  if (lo_cnt_inc >= LowMaxCnt) begin
                     fvalid_d   = 1'b1;
                     fdata_d    = shreg_q;
                     flen_d     = len_q;
                     ferr_d     = 1'b1;
                     state_d    = StArm;
                     lo_cnt_d   = '0;
                     hi_cnt_d   = '0;
                     pend_vld_d = 1'b0;
                  end
               end
            end
            StHigh: begin
               if (fall) begin
                  state_d  = StLow;
                  lo_cnt_d = CNT_W'(1);
                  hi_cnt_d = '0;
               end else begin
                  hi_cnt_d = hi_cnt_inc;
                  if (hi_cnt_inc >= IdleCnt) begin
                     fvalid_d   = 1'b1;
                     fdata_d    = shreg_q;
                     flen_d     = len_q;
                     ferr_d     = ovf_q | ~pend_bit_q;
                     state_d    = StIdle;
                     hi_cnt_d   = '0;
                     pend_vld_d = 1'b0;
                  end
               end
            end
            default: state_d = StArm;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StArm;
         line_q     <= 1'b1;
         lo_cnt_q   <= '0;
         hi_cnt_q   <= '0;
         shreg_q    <= '0;
         len_q      <= '0;
         ovf_q      <= 1'b0;
         pend_vld_q <= 1'b0;
         pend_bit_q <= 1'b0;
         fvalid_q   <= 1'b0;
         fdata_q    <= '0;
         flen_q     <= '0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_q     <= line;
         lo_cnt_q   <= lo_cnt_d;
         hi_cnt_q   <= hi_cnt_d;
         shreg_q    <= shreg_d;
         len_q      <= len_d;
         ovf_q      <= ovf_d;
         pend_vld_q <= pend_vld_d;
         pend_bit_q <= pend_bit_d;
         fvalid_q   <= fvalid_d;
         fdata_q    <= fdata_d;
         flen_q     <= flen_d;
         ferr_q     <= ferr_d;
      end
   end

`ifdef GC_JOYBUS_RX_BYTE_STROBE_EN
   logic byte_evt;

   // len only ever steps by one on a commit; clears never match.
   assign byte_evt = (len_d == len_q + 7'd1) && (len_d[2:0] == 3'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_valid <= 1'b0;
         byte_data  <= '0;
      end else begin
         byte_valid <= byte_evt;
         if (byte_evt) begin
            byte_data <= shreg_d[7:0];
         end
      end
   end
`endif

endmodule

// File: tb/tb_gc_joybus_rx.sv
// Scoreboard bench for gc_joybus_rx: stimulus pushes expected frames, a monitor pops on strobe.
module tb_gc_joybus_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        line = 1'b1;
   logic        rx_en = 1'b1;
   logic        busy;
   logic        frame_valid;
   logic [63:0] frame_data;
   logic [6:0]  frame_len;
   logic        frame_err;
`ifdef GC_JOYBUS_RX_BYTE_STROBE_EN
   logic [7:0]  byte_data;
   logic        byte_valid;
`endif

   gc_joybus_rx dut (
      .clk         (clk),
      .rst         (rst),
      .line        (line),
      .rx_en       (rx_en),
      .busy        (busy),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .frame_len   (frame_len),
      .frame_err   (frame_err)
`ifdef GC_JOYBUS_RX_BYTE_STROBE_EN
      ,
      .byte_data   (byte_data),
      .byte_valid  (byte_valid)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] data;
      logic [6:0]  len;
      logic        err;
      logic        chk_data;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic [7:0] bq[$];
   int         tests = 0;
   int         fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && frame_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got len %0d err %0b, expected no strobe",
                     frame_len, frame_err);
         end else begin
            e = sb.pop_front();
            if (e.chk_data) check("frame_data", frame_data, e.data);
            check("frame_len", 64'(frame_len), 64'(e.len));
            check("frame_err", 64'(frame_err), 64'(e.err));
         end
      end
   end

`ifdef GC_JOYBUS_RX_BYTE_STROBE_EN
   always @(negedge clk) begin
      if (!rst && byte_valid) begin
         if (bq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got %h expected no strobe", byte_data);
         end else begin
            check("byte_data", 64'(byte_data), 64'(bq.pop_front()));
         end
      end
   end
`endif

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hold(input logic v, input int n);
      line = v;
      cyc(n);
   endtask

   task automatic send_bit(input logic b);
      hold(1'b0, b ? 50 : 150);
      hold(1'b1, b ? 150 : 50);
   endtask

   task automatic send_stop();
      hold(1'b0, 50);
      hold(1'b1, 260);
   endtask

   task automatic push(input logic [63:0] d, input logic [6:0] l, input logic er,
                       input logic cd);
      exp_t x;
      x.data = d;
      x.len = l;
      x.err = er;
      x.chk_data = cd;
      sb.push_back(x);
   endtask

   initial begin
      cyc(3);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_frame_valid", 64'(frame_valid), 64'd0);
      check("rst_frame_data", frame_data, 64'd0);
      check("rst_frame_len", 64'(frame_len), 64'd0);
      check("rst_frame_err", 64'(frame_err), 64'd0);
      rst = 1'b0;

      // 249 high cycles is one short of arming: the low pulse must be ignored.
      hold(1'b1, 249);
      line = 1'b0;
      cyc(1);
      check("unarmed_busy", 64'(busy), 64'd0);
      cyc(49);
      hold(1'b1, 260);

      push(64'h1, 7'd2, 1'b0, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_stop();

      push(64'h0, 7'd0, 1'b0, 1'b1);
      send_stop();

      push(64'hAAAA_AAAA_AAAA_AAAA, 7'd64, 1'b0, 1'b1);
      for (int i = 0; i < 64; i++) send_bit((i % 2) == 0);
      send_stop();

      push(64'hAAAA_AAAA_AAAA_AAAA, 7'd64, 1'b1, 1'b1);
      for (int i = 0; i < 65; i++) send_bit((i % 2) == 0);
      send_stop();

      // Stop bit with a '0' low time.
      push(64'h3, 7'd2, 1'b1, 1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      hold(1'b0, 150);
      hold(1'b1, 260);

      push(64'h1, 7'd1, 1'b1, 1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      hold(1'b0, 410);
      hold(1'b1, 100);
      line = 1'b0;
      cyc(1);
      check("stuck_rearm_busy", 64'(busy), 64'd0);
      cyc(49);
      hold(1'b1, 260);

      push(64'h5, 7'd3, 1'b0, 1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_stop();

      for (int i = 0; i < 10; i++) send_bit(1'b1);
      check("pre_abort_busy", 64'(busy), 64'd1);
      rx_en = 1'b0;
      cyc(1);
      check("abort_busy", 64'(busy), 64'd0);
      cyc(20);
      rx_en = 1'b1;
      hold(1'b1, 260);

      push(64'hD, 7'd4, 1'b0, 1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_stop();

`ifdef GC_JOYBUS_RX_BYTE_STROBE_EN
      push(64'h5AC3, 7'd16, 1'b0, 1'b1);
      bq.push_back(8'h5A);
      bq.push_back(8'hC3);
      for (int i = 7; i >= 0; i--) send_bit(((8'h5A >> i) & 8'h1) != 0);
      for (int i = 7; i >= 0; i--) send_bit(((8'hC3 >> i) & 8'h1) != 0);
      send_stop();
      check("bytes_pending", 64'(bq.size()), 64'd0);
`endif

      cyc(20);
      check("frames_pending", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
